booth_prod_acc: RTL and testbench



---
 rtl/booth_prod_acc.sv | 101 ++++++++++
 tb/tb_booth_prod_acc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/booth_prod_acc.sv
// Block accumulator for signed Booth multiplier products, with a valid/ready result port.
// Optional BOOTH_PROD_ACC_SAT_EN: clamp the accumulator on signed overflow instead of wrapping.
module booth_prod_acc #(
    parameter  int PROD_W = 16,
    parameter  int ACC_W  = 24,
    parameter  int LEN    = 8,
    localparam int CNT_W  = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_valid;

    logic [ACC_W-1:0]   w_ext;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf;
    logic               w_close;
    logic               w_accept;

    assign w_ext     = ACC_W'($signed(in_prod));
    assign w_sum     = r_acc + w_ext;
    // Overflow: both addends share a sign and the sum's sign flipped.
    assign w_ovf     = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_close   = in_last || (w_cnt_nxt == CNT_W'(LEN));
    assign in_ready  = (r_state == ACC) && !clr;
    assign w_accept  = in_valid && in_ready;

`ifdef BOOTH_PROD_ACC_SAT_EN
    assign w_acc_nxt = !w_ovf          ? w_sum :
                       r_acc[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                         {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_acc_nxt = w_sum;
`endif

    assign out_valid = r_valid;
    assign out_acc   = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (clr) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= r_ovf | w_ovf;
                        if (w_close) begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= ACC;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_prod_acc.sv
// Directed bench for booth_prod_acc (ACC_W=16, LEN=4) with an arithmetic reference model.
module tb_booth_prod_acc;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 16;
    localparam int LEN    = 4;
    localparam int CNT_W  = $clog2(LEN + 1);
    localparam longint MAXV = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W - 1));
    localparam longint SPAN = 64'sd1 <<< ACC_W;

    logic                     clk, rst_n, clr, in_valid, in_ready, in_last;
    logic                     out_valid, out_ready, out_ovf;
    logic signed [PROD_W-1:0] in_prod;
    logic signed [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]         out_count;

    int n_tests = 0;
    int n_fail  = 0;

    booth_prod_acc #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: exact integer sum, then wrap or clamp into the ACC_W range.
    function automatic longint model_add(input longint a, input longint p);
        longint t;
        t = a + p;
`ifdef BOOTH_PROD_ACC_SAT_EN
        if (t > MAXV) t = MAXV;
        else if (t < MINV) t = MINV;
`else
        if (t > MAXV) t = t - SPAN;
        else if (t < MINV) t = t + SPAN;
`endif
        return t;
    endfunction

    function automatic bit model_ovf(input longint a, input longint p);
        return (a + p > MAXV) || (a + p < MINV);
    endfunction

    longint m_acc;
    int     m_cnt;
    bit     m_ovf, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr || (m_done && out_ready)) begin
            m_acc <= 0; m_cnt <= 0; m_ovf <= 0; m_done <= 0;
        end else if (!m_done && in_valid) begin
            m_acc <= model_add(m_acc, longint'(in_prod));
            m_ovf <= m_ovf | model_ovf(m_acc, longint'(in_prod));
            m_cnt <= m_cnt + 1;
            if (in_last || (m_cnt + 1 == LEN)) m_done <= 1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            chk("in_ready", longint'(in_ready), longint'(!m_done && !clr));
            chk("out_valid", longint'(out_valid), longint'(m_done));
            if (m_done) begin
                chk("out_acc", longint'(out_acc), m_acc);
                chk("out_count", longint'(out_count), longint'(m_cnt));
                chk("out_ovf", longint'(out_ovf), longint'(m_ovf));
            end
        end
    end

    task automatic drv(input bit v, input logic signed [PROD_W-1:0] p, input bit last);
        @(negedge clk);
        in_valid = v; in_prod = p; in_last = last;
    endtask

    task automatic dlv();
        @(negedge clk);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        #1;
        chk("ready_after_dlv", longint'(in_ready), 1);
        chk("valid_after_dlv", longint'(out_valid), 0);
    endtask

    initial begin
        clk = 0; rst_n = 0; clr = 0; in_valid = 0; in_prod = '0; in_last = 0; out_ready = 0;
        #1;
        chk("rst_acc", longint'(out_acc), 0);
        chk("rst_count", longint'(out_count), 0);
        chk("rst_ovf", longint'(out_ovf), 0);
        chk("rst_valid", longint'(out_valid), 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk); #1;
        chk("rst_ready", longint'(in_ready), 1);

        // reset mid-block
        drv(1, 3, 0); drv(1, -15, 0); drv(0, 0, 0);
        #1;
        chk("mid_acc", longint'(out_acc), -12);
        chk("mid_count", longint'(out_count), 2);
        @(negedge clk); rst_n = 0;
        #1;
        chk("arst_acc", longint'(out_acc), 0);
        chk("arst_count", longint'(out_count), 0);
        chk("arst_valid", longint'(out_valid), 0);
        @(negedge clk); rst_n = 1;
        #1;
        chk("arst_ready", longint'(in_ready), 1);

        // full block of LEN products
        drv(1, 6, 0); drv(1, -15, 0); drv(1, 100, 0); drv(1, -1, 0); drv(0, 0, 0);
        #1;
        chk("full_valid", longint'(out_valid), 1);
        chk("full_acc", longint'(out_acc), 90);
        chk("full_count", longint'(out_count), 4);
        chk("full_ovf", longint'(out_ovf), 0);
        chk("full_ready", longint'(in_ready), 0);
        dlv();

        // early close, backpressure, and a product offered during DONE
        drv(1, 16129, 1); drv(1, 555, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_acc", longint'(out_acc), 16129);
            chk("bp_count", longint'(out_count), 1);
            chk("bp_valid", longint'(out_valid), 1);
        end
        @(negedge clk); in_valid = 0; out_ready = 1;
        @(negedge clk); out_ready = 0;
        #1;
        chk("bp_ready_next", longint'(in_ready), 1);
        chk("bp_count_clr", longint'(out_count), 0);

        // signed overflow
        drv(1, 16384, 0); drv(1, 16384, 0); drv(1, 16384, 1); drv(0, 0, 0);
        #1;
`ifdef BOOTH_PROD_ACC_SAT_EN
        chk("ovf_acc", longint'(out_acc), 32767);
`else
        chk("ovf_acc", longint'(out_acc), -16384);
`endif
        chk("ovf_flag", longint'(out_ovf), 1);
        chk("ovf_count", longint'(out_count), 3);
        dlv();

        // clr colliding with a product
        drv(1, 5, 0); drv(1, 7, 0);
        @(negedge clk); clr = 1; in_valid = 1; in_prod = 9; in_last = 0;
        #1;
        chk("clr_ready", longint'(in_ready), 0);
        @(negedge clk); clr = 0; in_valid = 0;
        #1;
        chk("clr_count", longint'(out_count), 0);
        chk("clr_acc", longint'(out_acc), 0);
        drv(1, 1, 0); drv(1, 2, 1); drv(0, 0, 0);
        #1;
        chk("post_clr_acc", longint'(out_acc), 3);
        chk("post_clr_count", longint'(out_count), 2);
        dlv();

        // clr while holding a result
        drv(1, 4, 1); drv(0, 0, 0);
        @(negedge clk); clr = 1;
        @(negedge clk); clr = 0;
        #1;
        chk("clr_done_valid", longint'(out_valid), 0);
        chk("clr_done_count", longint'(out_count), 0);

        // negative extremes from the 8x8 multiplier
        drv(1, -16256, 0); drv(1, 16384, 1); drv(0, 0, 0);
        #1;
        chk("neg_acc", longint'(out_acc), 128);
        chk("neg_count", longint'(out_count), 2);
        chk("neg_ovf", longint'(out_ovf), 0);
        dlv();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
